axil_master_bridge: RTL and testbench

//  AXI4-Lite initiator for fabric logic: accepts single read/write commands on a valid/ready port,

---
 rtl/axil_pkg.sv | 21 ++
 rtl/axil_master_bridge.sv | 200 ++++++++++++++++++++
 tb/tb_axil_master_bridge.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the fabric-side bridge: response codes,
// default protection attributes and the bridge FSM state encoding.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_DATA,
    RSP
  } bridge_state_e;

endpackage

// File: rtl/axil_master_bridge.sv
// AXI4-Lite initiator: turns single valid/ready commands into AW/W/B or AR/R
// transactions, one outstanding at a time, and returns one response per command.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                      axi_clock,
  input  logic                      rst_n,

  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_we,
  input  logic [ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_we,
  output logic [DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,

  output logic [ADDR_WIDTH+1:0]     m_axil_awaddr,
  output logic [2:0]                m_axil_awprot,
  output logic                      m_axil_awvalid,
  input  logic                      m_axil_awready,
  output logic [DATA_WIDTH-1:0]     m_axil_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axil_wstrb,
  output logic                      m_axil_wvalid,
  input  logic                      m_axil_wready,
  input  logic [1:0]                m_axil_bresp,
  input  logic                      m_axil_bvalid,
  output logic                      m_axil_bready,
  output logic [ADDR_WIDTH+1:0]     m_axil_araddr,
  output logic [2:0]                m_axil_arprot,
  output logic                      m_axil_arvalid,
  input  logic                      m_axil_arready,
  input  logic [DATA_WIDTH-1:0]     m_axil_rdata,
  input  logic [1:0]                m_axil_rresp,
  input  logic                      m_axil_rvalid,
  output logic                      m_axil_rready
);

  bridge_state_e state_q, state_d;

  logic aw_done_q, aw_done_d;
  logic w_done_q,  w_done_d;

  logic cmd_ready_q, cmd_ready_d;
  logic awvalid_q,   awvalid_d;
  logic wvalid_q,    wvalid_d;
  logic bready_q,    bready_d;
  logic arvalid_q,   arvalid_d;
  logic rready_q,    rready_d;
  logic rsp_valid_q, rsp_valid_d;

  logic [ADDR_WIDTH+1:0]   axi_addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic                    rsp_we_q;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q;
  logic [1:0]              rsp_resp_q;

  logic cmd_accept;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, rsp_hs;

  // Handshakes are qualified by our own registered valid/ready, so stray
  // responder valids outside the owning state are never taken.
  assign cmd_accept = cmd_valid      && cmd_ready_q;
  assign aw_hs      = awvalid_q      && m_axil_awready;
  assign w_hs       = wvalid_q       && m_axil_wready;
  assign b_hs       = m_axil_bvalid  && bready_q;
  assign ar_hs      = arvalid_q      && m_axil_arready;
  assign r_hs       = m_axil_rvalid  && rready_q;
  assign rsp_hs     = rsp_valid_q    && rsp_ready;

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      IDLE: begin
        aw_done_d = '0;
        w_done_d  = '0;
        if (cmd_accept) begin
          state_d = cmd_we ? WR_REQ : RD_REQ;
        end
      end
      WR_REQ: begin
        if (aw_hs) aw_done_d = '1;
        if (w_hs)  w_done_d  = '1;
        if (aw_done_d && w_done_d) begin
          state_d = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) state_d = RSP;
      end
      RD_REQ: begin
        if (ar_hs) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (r_hs) state_d = RSP;
      end
      RSP: begin
        if (rsp_hs) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are decoded from the next state and registered, so each valid
    // falls on the edge right after its own handshake.
    cmd_ready_d = (state_d == IDLE);
    awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
    wvalid_d    = (state_d == WR_REQ) && !w_done_d;
    bready_d    = (state_d == WR_RESP);
    arvalid_d   = (state_d == RD_REQ);
    rready_d    = (state_d == RD_DATA);
    rsp_valid_d = (state_d == RSP);
  end

  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aw_done_q   <= '0;
      w_done_q    <= '0;
      cmd_ready_q <= '0;
      awvalid_q   <= '0;
      wvalid_q    <= '0;
      bready_q    <= '0;
      arvalid_q   <= '0;
      rready_q    <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_ff @(posedge axi_clock or negedge rst_n) begin
    if (!rst_n) begin
      axi_addr_q  <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_we_q    <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      if (cmd_accept) begin
        axi_addr_q  <= {cmd_addr, 2'b00};
        rsp_we_q    <= cmd_we;
        rsp_rdata_q <= '0;
        rsp_resp_q  <= '0;
        if (cmd_we) begin
          wdata_q <= cmd_wdata;
          wstrb_q <= cmd_wstrb;
        end
      end
      if (b_hs) begin
        rsp_resp_q <= m_axil_bresp;
      end
      if (r_hs) begin
        rsp_rdata_q <= m_axil_rdata;
        rsp_resp_q  <= m_axil_rresp;
      end
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_we         = rsp_we_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;

  assign m_axil_awaddr  = axi_addr_q;
  assign m_axil_awprot  = AXI_PROT_DEFAULT;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = wstrb_q;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = axi_addr_q;
  assign m_axil_arprot  = AXI_PROT_DEFAULT;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Bench for axil_master_bridge: a small memory-backed AXI-Lite responder with
// programmable ready delays and response codes, driven by a vector table.
module tb_axil_master_bridge;
  import axil_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [9:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_we;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [11:0] awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  axil_master_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
    .axi_clock(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- responder model ----------------
  int unsigned aw_delay, w_delay;
  logic [1:0]  cfg_bresp, cfg_rresp;
  int unsigned aw_cnt, w_cnt;
  logic        aw_got, w_got;
  logic [11:0] aw_a;
  logic [31:0] w_d;
  logic [3:0]  w_s;
  logic [31:0] mem [1024];
  logic        aw_hs_q, w_hs_q, ar_hs_q;
  logic [11:0] last_awaddr, last_araddr;
  int unsigned rsp_count = 0;

  wire         aw_hs   = awvalid && awready;
  wire         w_hs    = wvalid && wready;
  wire         aw_have = aw_got || aw_hs;
  wire         w_have  = w_got || w_hs;
  wire [11:0]  eff_aw  = aw_got ? aw_a : awaddr;
  wire [31:0]  eff_wd  = w_got ? w_d : wdata;
  wire [3:0]   eff_ws  = w_got ? w_s : wstrb;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0;
      bvalid <= 1'b0; rvalid <= 1'b0; bresp <= 2'b00; rresp <= 2'b00; rdata <= '0;
      aw_cnt <= 0; w_cnt <= 0; aw_got <= 1'b0; w_got <= 1'b0;
      aw_hs_q <= 1'b0; w_hs_q <= 1'b0; ar_hs_q <= 1'b0;
    end else begin
      aw_hs_q <= aw_hs;
      w_hs_q  <= w_hs;
      ar_hs_q <= arvalid && arready;
      arready <= 1'b1;
      if (aw_hs) begin
        aw_a <= awaddr; last_awaddr <= awaddr;
        awready <= (aw_delay == 0); aw_cnt <= 0;
      end else if (awvalid && !awready) begin
        aw_cnt <= aw_cnt + 1;
        if (aw_cnt + 1 >= aw_delay) awready <= 1'b1;
      end else if (!awvalid) begin
        awready <= (aw_delay == 0); aw_cnt <= 0;
      end
      if (w_hs) begin
        w_d <= wdata; w_s <= wstrb;
        wready <= (w_delay == 0); w_cnt <= 0;
      end else if (wvalid && !wready) begin
        w_cnt <= w_cnt + 1;
        if (w_cnt + 1 >= w_delay) wready <= 1'b1;
      end else if (!wvalid) begin
        wready <= (w_delay == 0); w_cnt <= 0;
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0;
      end else if (!bvalid && aw_have && w_have) begin
        mem[eff_aw[11:2]] <= merge(mem[eff_aw[11:2]], eff_wd, eff_ws);
        bvalid <= 1'b1; bresp <= cfg_bresp;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
      end else if (arvalid && arready) begin
        last_araddr <= araddr;
        rvalid <= 1'b1; rdata <= mem[araddr[11:2]]; rresp <= cfg_rresp;
      end
    end
  end

  always @(posedge clk) begin
    if (rsp_valid && rsp_ready) rsp_count <= rsp_count + 1;
  end

  // Protocol watch: valids hold until handshake, drop right after it, payload
  // stable meanwhile, and bready never overlaps a pending AW/W.
  logic        pv_aw = 1'b0, pv_w = 1'b0, pv_ar = 1'b0;
  logic [11:0] pv_awaddr, pv_araddr;
  logic [31:0] pv_wdata;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pv_aw) begin
        if (aw_hs_q) check("awvalid_drop", 32'(awvalid), 32'd0);
        else begin
          check("awvalid_hold", 32'(awvalid), 32'd1);
          check("awaddr_stable", 32'(awaddr), 32'(pv_awaddr));
        end
      end
      if (pv_w) begin
        if (w_hs_q) check("wvalid_drop", 32'(wvalid), 32'd0);
        else begin
          check("wvalid_hold", 32'(wvalid), 32'd1);
          check("wdata_stable", wdata, pv_wdata);
        end
      end
      if (pv_ar) begin
        if (ar_hs_q) check("arvalid_drop", 32'(arvalid), 32'd0);
        else begin
          check("arvalid_hold", 32'(arvalid), 32'd1);
          check("araddr_stable", 32'(araddr), 32'(pv_araddr));
        end
      end
      if (bready) check("bready_after_aw_w", 32'(awvalid | wvalid), 32'd0);
    end
    pv_aw <= rst_n && awvalid;
    pv_w  <= rst_n && wvalid;
    pv_ar <= rst_n && arvalid;
    pv_awaddr <= awaddr;
    pv_araddr <= araddr;
    pv_wdata  <= wdata;
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int unsigned aw_dly;
    int unsigned w_dly;
    logic [1:0]  bresp_cfg;
    logic [1:0]  rresp_cfg;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    logic [11:0] exp_axaddr;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic we, input logic [9:0] addr, input logic [31:0] wd,
                              input logic [3:0] ws, input int unsigned awd, input int unsigned wdl,
                              input logic [1:0] bcfg, input logic [1:0] rcfg,
                              input logic [31:0] erd, input logic [1:0] ersp,
                              input logic [11:0] eax);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wd; v.wstrb = ws; v.aw_dly = awd; v.w_dly = wdl;
    v.bresp_cfg = bcfg; v.rresp_cfg = rcfg; v.exp_rdata = erd; v.exp_resp = ersp;
    v.exp_axaddr = eax;
    return v;
  endfunction

  task automatic run_vec(input int idx);
    vec_t v;
    int unsigned n, lat, cnt0, exp_lat;
    v = vecs[idx];
    aw_delay = v.aw_dly; w_delay = v.w_dly;
    cfg_bresp = v.bresp_cfg; cfg_rresp = v.rresp_cfg;
    cnt0 = rsp_count;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = v.we; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    check($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_wdata = '0; cmd_wstrb = '0; cmd_addr = '0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
    exp_lat = 3;
    if (v.we) exp_lat = 3 + ((v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly);
    check($sformatf("v%0d_latency", idx), lat, exp_lat);
    check($sformatf("v%0d_rsp_we", idx), 32'(rsp_we), 32'(v.we));
    check($sformatf("v%0d_rsp_rdata", idx), rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_rsp_resp", idx), 32'(rsp_resp), 32'(v.exp_resp));
    check($sformatf("v%0d_axaddr", idx), 32'(v.we ? last_awaddr : last_araddr),
          32'(v.exp_axaddr));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_done", idx), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d_idle_ready", idx), 32'(cmd_ready), 32'd1);
    check($sformatf("v%0d_rsp_count", idx), rsp_count - cnt0, 32'd1);
  endtask

  logic [31:0] hold_rdata;
  logic [1:0]  hold_resp;
  int unsigned n, cnt0;

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    aw_delay = 0; w_delay = 0; cfg_bresp = OKAY; cfg_rresp = OKAY;

    //                 we    addr      wdata          strb aw w  bresp   rresp   exp_rdata      resp    axaddr
    vecs[0]  = mk(1'b1, 10'd5,    32'hDEADBEEF, 4'hF, 0, 0, OKAY,   OKAY,   32'h0,         OKAY,   12'h014);
    vecs[1]  = mk(1'b0, 10'd5,    32'h0,        4'h0, 0, 0, OKAY,   OKAY,   32'hDEADBEEF,  OKAY,   12'h014);
    vecs[2]  = mk(1'b1, 10'd5,    32'h0000CAFE, 4'h3, 0, 0, OKAY,   OKAY,   32'h0,         OKAY,   12'h014);
    vecs[3]  = mk(1'b0, 10'd5,    32'h0,        4'h0, 0, 0, OKAY,   OKAY,   32'hDEADCAFE,  OKAY,   12'h014);
    vecs[4]  = mk(1'b1, 10'd10,   32'h12345678, 4'hF, 4, 0, OKAY,   OKAY,   32'h0,         OKAY,   12'h028);
    vecs[5]  = mk(1'b1, 10'd11,   32'hA5A5A5A5, 4'hF, 0, 4, OKAY,   OKAY,   32'h0,         OKAY,   12'h02C);
    vecs[6]  = mk(1'b1, 10'd12,   32'h0BADF00D, 4'hF, 2, 2, OKAY,   OKAY,   32'h0,         OKAY,   12'h030);
    vecs[7]  = mk(1'b1, 10'd13,   32'h11223344, 4'hF, 0, 0, SLVERR, OKAY,   32'h0,         SLVERR, 12'h034);
    vecs[8]  = mk(1'b0, 10'd10,   32'h0,        4'h0, 0, 0, OKAY,   DECERR, 32'h12345678,  DECERR, 12'h028);
    vecs[9]  = mk(1'b0, 10'd11,   32'h0,        4'h0, 0, 0, OKAY,   OKAY,   32'hA5A5A5A5,  OKAY,   12'h02C);
    vecs[10] = mk(1'b0, 10'd12,   32'h0,        4'h0, 0, 0, OKAY,   OKAY,   32'h0BADF00D,  OKAY,   12'h030);
    vecs[11] = mk(1'b1, 10'd10,   32'hFF000000, 4'h8, 1, 3, OKAY,   OKAY,   32'h0,         OKAY,   12'h028);
    vecs[12] = mk(1'b0, 10'd10,   32'h0,        4'h0, 0, 0, OKAY,   OKAY,   32'hFF345678,  OKAY,   12'h028);
    vecs[13] = mk(1'b1, 10'd1023, 32'hCAFEF00D, 4'hF, 0, 0, OKAY,   OKAY,   32'h0,         OKAY,   12'hFFC);
    vecs[14] = mk(1'b0, 10'd1023, 32'h0,        4'h0, 0, 0, OKAY,   OKAY,   32'hCAFEF00D,  OKAY,   12'hFFC);
    vecs[15] = mk(1'b0, 10'd5,    32'h0,        4'h0, 0, 0, OKAY,   OKAY,   32'hDEADCAFE,  OKAY,   12'h014);

    repeat (3) @(negedge clk);
    check("reset_valids", 32'({cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}), 32'd0);
    check("reset_awaddr", 32'(awaddr), 32'd0);
    check("reset_araddr", 32'(araddr), 32'd0);
    check("reset_wdata", wdata, 32'd0);
    check("reset_wstrb_prot", 32'({wstrb, awprot, arprot}), 32'd0);
    check("reset_rsp_fields", 32'({rsp_we, rsp_resp}), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 15; i++) run_vec(i);

    // Response back-pressure: fields hold and a new command is ignored.
    aw_delay = 0; w_delay = 0; cfg_bresp = OKAY; cfg_rresp = OKAY;
    cnt0 = rsp_count;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_addr = 10'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_we = 1'b1; cmd_addr = 10'd7; cmd_wdata = 32'h55555555; cmd_wstrb = 4'hF;
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    hold_rdata = rsp_rdata;
    hold_resp  = rsp_resp;
    check("bp_rdata", hold_rdata, 32'hDEADCAFE);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(rsp_valid), 32'd1);
      check("bp_hold_rdata", rsp_rdata, hold_rdata);
      check("bp_hold_resp_we", 32'({rsp_we, rsp_resp}), 32'({1'b0, hold_resp}));
      check("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
      check("bp_no_new_req", 32'({awvalid, wvalid, arvalid}), 32'd0);
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_rsp_done", 32'(rsp_valid), 32'd0);
    check("bp_idle_ready", 32'(cmd_ready), 32'd1);
    check("bp_rsp_count", rsp_count - cnt0, 32'd1);

    // Reset in the middle of a write with AW stalled.
    aw_delay = 6; w_delay = 0;
    cnt0 = rsp_count;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 10'd20; cmd_wdata = 32'h77777777; cmd_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!awvalid && n < 20) begin @(negedge clk); n++; end
    check("rst_mid_awvalid_seen", 32'(awvalid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valids_low", 32'({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_cmd_ready", 32'(cmd_ready), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_mid_quiet", 32'({awvalid, wvalid, rsp_valid}), 32'd0);
    end
    check("rst_mid_no_rsp", rsp_count - cnt0, 32'd0);
    run_vec(15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
